// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - commit-stage exception/interrupt/ERET arbiter
//
// Picks at most one event per cycle from the two committing slots:
// an interrupt, an exception or an ERET. Slot 0 is the older instruction.
// kill is combinational in the decision cycle. The exception/ERET record,
// redirect and flush are registered and appear one cycle later. The FSM then
// spends FLUSH_CYCLES cycles ignoring slot inputs.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   slot_*[1:0]        per-slot commit information (valid, pc, delay slot,
//                      exception flag/code/badvaddr, refill flag, eret)
//   status_*           CP0 Status IE/EXL/ERL/IM
//   cause_ip_sw        Cause.IP[1:0] software interrupts
//   epc                CP0 EPC, the ERET target
//   timer_interrupt    registered timer request, not synchronized
//   ext_int            asynchronous hardware interrupt lines
//   kill               per-slot writeback suppress, combinational
//   exc_*              registered exception record to CP0
//   eret               registered ERET pulse to CP0
//   redirect_valid/pc  registered front-end redirect
//   flush              registered pipeline flush
//   ip_hw              Cause.IP[7:2] value for CP0
module exc_commit #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
    parameter logic [31:0] REFILL_VECTOR = 32'hBFC0_0200,
    parameter int unsigned FLUSH_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       slot_valid,
    input  logic [1:0][31:0] slot_pc,
    input  logic [1:0]       slot_in_ds,
    input  logic [1:0]       slot_exc,
    input  logic [1:0][4:0]  slot_code,
    input  logic [1:0][31:0] slot_badvaddr,
    input  logic [1:0]       slot_refill,
    input  logic [1:0]       slot_eret,
    input  logic             status_ie,
    input  logic             status_exl,
    input  logic             status_erl,
    input  logic [7:0]       status_im,
    input  logic [1:0]       cause_ip_sw,
    input  logic [31:0]      epc,
    input  logic             timer_interrupt,
    input  logic [5:0]       ext_int,
    output logic [1:0]       kill,
    output logic             exc_valid,
    output logic [4:0]       exc_code,
    output logic [31:0]      exc_pc,
    output logic             exc_in_ds,
    output logic [31:0]      exc_badvaddr,
    output logic             eret,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [5:0]       ip_hw
);

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [5:0]  int_m;
    logic [5:0]  int_s;
    logic        int_req;

    logic        ev;
    logic        ev_int;
    logic        ev_eret;
    logic        ev_slot;
    logic [4:0]  sel_code;
    logic [31:0] sel_badvaddr;
    logic        refill_hit;
    logic [31:0] target;

    // Timer shares IP7 with ext_int[5] and is already registered in CP0.
    assign ip_hw   = {int_s[5] | timer_interrupt, int_s[4:0]};
    assign int_req = status_ie & ~status_exl & ~status_erl &
                     (|({ip_hw, cause_ip_sw} & status_im));

    // Event selection, kill and next-state.
    always_comb begin
        ev        = 1'b0;
        ev_int    = 1'b0;
        ev_eret   = 1'b0;
        ev_slot   = 1'b0;
        kill      = 2'b00;
        state_nxt = state;
        cnt_nxt   = cnt;

        if (state == ST_IDLE) begin
            if (int_req && (|slot_valid)) begin
                // Interrupt is charged to the oldest valid instruction.
                ev      = 1'b1;
                ev_int  = 1'b1;
                ev_slot = ~slot_valid[0];
            end else if (slot_valid[0] && slot_exc[0]) begin
                ev      = 1'b1;
            end else if (slot_valid[0] && slot_eret[0]) begin
                ev      = 1'b1;
                ev_eret = 1'b1;
            end else if (slot_valid[1] && slot_exc[1]) begin
                ev      = 1'b1;
                ev_slot = 1'b1;
            end else if (slot_valid[1] && slot_eret[1]) begin
                ev      = 1'b1;
                ev_eret = 1'b1;
                ev_slot = 1'b1;
            end

            if (ev) begin
                // Slot 1 events let the older slot 0 retire.
                kill      = ev_slot ? 2'b10 : 2'b11;
                state_nxt = ST_FLUSH;
                cnt_nxt   = FLUSH_LOAD;
            end
        end else begin
            kill = slot_valid;
            if (cnt == 3'd0) begin
                state_nxt = ST_IDLE;
            end else begin
                cnt_nxt = cnt - 3'd1;
            end
        end
    end

    // Record contents for the selected slot.
    always_comb begin
        sel_code     = ev_int ? 5'd0 : slot_code[ev_slot];
        sel_badvaddr = ev_int ? 32'd0 : slot_badvaddr[ev_slot];
        // Refill vector only for a TLB miss with no matching entry taken
        // outside exception level.
        refill_hit   = ~ev_int & ~status_exl & slot_refill[ev_slot] &
                       ((sel_code == 5'd2) || (sel_code == 5'd3));
        if (ev_eret) begin
            target = epc;
        end else if (refill_hit) begin
            target = REFILL_VECTOR;
        end else begin
            target = EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            int_m <= 6'd0;
            int_s <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            int_m <= ext_int;
            int_s <= int_m;
        end
    end

    // Registered record: one-cycle pulse; fields read zero when not valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_valid      <= 1'b0;
            exc_code       <= 5'd0;
            exc_pc         <= 32'd0;
            exc_in_ds      <= 1'b0;
            exc_badvaddr   <= 32'd0;
            eret           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush          <= 1'b0;
        end else begin
            exc_valid      <= ev & ~ev_eret;
            exc_code       <= (ev && !ev_eret) ? sel_code : 5'd0;
            exc_pc         <= (ev && !ev_eret) ? slot_pc[ev_slot] : 32'd0;
            exc_in_ds      <= ev & ~ev_eret & slot_in_ds[ev_slot];
            exc_badvaddr   <= (ev && !ev_eret) ? sel_badvaddr : 32'd0;
            eret           <= ev & ev_eret;
            redirect_valid <= ev;
            redirect_pc    <= ev ? target : 32'd0;
            flush          <= ev;
        end
    end

endmodule

// File: tb/tb_exc_commit.sv
// tb/tb_exc_commit.sv - self-checking bench for exc_commit
module tb_exc_commit;

    localparam logic [31:0] EXC_V = 32'hBFC0_0380;
    localparam logic [31:0] REF_V = 32'hBFC0_0200;
    localparam int FC = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       slot_valid, slot_in_ds, slot_exc, slot_refill, slot_eret;
    logic [1:0][31:0] slot_pc, slot_badvaddr;
    logic [1:0][4:0]  slot_code;
    logic             status_ie, status_exl, status_erl;
    logic [7:0]       status_im;
    logic [1:0]       cause_ip_sw;
    logic [31:0]      epc;
    logic             timer_interrupt;
    logic [5:0]       ext_int;
    logic [1:0]       kill;
    logic             exc_valid, exc_in_ds, eret, redirect_valid, flush;
    logic [4:0]       exc_code;
    logic [31:0]      exc_pc, exc_badvaddr, redirect_pc;
    logic [5:0]       ip_hw;

    int errors = 0;
    int checks = 0;

    exc_commit #(.EXC_VECTOR(EXC_V), .REFILL_VECTOR(REF_V), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .slot_valid(slot_valid), .slot_pc(slot_pc), .slot_in_ds(slot_in_ds),
        .slot_exc(slot_exc), .slot_code(slot_code), .slot_badvaddr(slot_badvaddr),
        .slot_refill(slot_refill), .slot_eret(slot_eret),
        .status_ie(status_ie), .status_exl(status_exl), .status_erl(status_erl),
        .status_im(status_im), .cause_ip_sw(cause_ip_sw), .epc(epc),
        .timer_interrupt(timer_interrupt), .ext_int(ext_int),
        .kill(kill), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_in_ds(exc_in_ds), .exc_badvaddr(exc_badvaddr), .eret(eret),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .ip_hw(ip_hw)
    );

    always #5 clk = ~clk;

    // Reference model: what should happen in a cycle, from the rules.
    typedef struct packed {
        logic        ev;
        logic        is_eret;
        logic [1:0]  kill;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] tgt;
    } dec_t;

    int         m_busy;       // remaining cycles in which slots are ignored
    logic [5:0] m_ext_d1;     // ext_int one edge ago
    logic [5:0] m_ext_d2;     // ext_int two edges ago
    dec_t       m_exp;        // record expected after the next edge

    function automatic logic [5:0] model_ip();
        return {m_ext_d2[5] | timer_interrupt, m_ext_d2[4:0]};
    endfunction

    function automatic dec_t decide();
        dec_t d;
        logic irq;
        int   s;
        d   = '0;
        s   = 0;
        irq = status_ie && !status_exl && !status_erl &&
              (({model_ip(), cause_ip_sw} & status_im) != 10'd0);
        if (m_busy > 0) begin
            d.kill = slot_valid;
            return d;
        end
        if (irq && slot_valid != 2'b00) begin
            s = slot_valid[0] ? 0 : 1;
            d.ev = 1'b1;
            d.code = 5'd0;
            d.bad = 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!d.ev && slot_valid[i] && slot_exc[i]) begin
                    d.ev = 1'b1; s = i; d.code = slot_code[i]; d.bad = slot_badvaddr[i];
                end else if (!d.ev && slot_valid[i] && slot_eret[i]) begin
                    d.ev = 1'b1; s = i; d.is_eret = 1'b1;
                end
            end
        end
        if (d.ev) begin
            d.pc   = slot_pc[s];
            d.ds   = slot_in_ds[s];
            d.kill = (s == 0) ? 2'b11 : 2'b10;
            if (d.is_eret)
                d.tgt = epc;
            else if ((d.code == 5'd2 || d.code == 5'd3) && slot_refill[s] && !status_exl && !irq)
                d.tgt = REF_V;
            else
                d.tgt = EXC_V;
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        slot_valid = 0; slot_in_ds = 0; slot_exc = 0; slot_refill = 0; slot_eret = 0;
        slot_pc = '0; slot_badvaddr = '0; slot_code = '0;
        status_ie = 0; status_exl = 0; status_erl = 0; status_im = 0;
        cause_ip_sw = 0; epc = 0; timer_interrupt = 0; ext_int = 0;
    endtask

    task automatic settle();
        drive_idle();
        repeat (FC + 1) tick();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        timer_interrupt = 1'b1;
        #1;
        checks++; if ({exc_valid, eret, redirect_valid, flush} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {exc_valid, eret, redirect_valid, flush}); end
        checks++; if (redirect_pc !== 32'd0) begin
            errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        checks++; if (kill !== 2'b00) begin
            errors++; $display("FAIL reset_kill: got %b want 00", kill); end
        checks++; if (ip_hw !== 6'b100000) begin
            errors++; $display("FAIL reset_ip_hw: got %b want 100000", ip_hw); end
        timer_interrupt = 1'b0;
        tick();
    endtask

    task automatic test_slot0_exc();
        slot_valid = 2'b01; slot_exc = 2'b01; slot_code[0] = 5'd4;
        slot_pc[0] = 32'h8000_1000; slot_badvaddr[0] = 32'h0000_0003;
        #1;
        checks++; if (kill !== 2'b11) begin
            errors++; $display("FAIL s0exc_kill: got %b want 11", kill); end
        tick();
        checks++; if (exc_valid !== 1'b1 || exc_code !== 5'd4 || exc_badvaddr !== 32'h3 || exc_pc !== 32'h8000_1000) begin
            errors++; $display("FAIL s0exc_record: got v=%b code=%0d bad=%h pc=%h want 1/4/3/80001000",
                               exc_valid, exc_code, exc_badvaddr, exc_pc); end
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== EXC_V || flush !== 1'b1 || eret !== 1'b0) begin
            errors++; $display("FAIL s0exc_redirect: got rv=%b pc=%h fl=%b eret=%b want 1/%h/1/0",
                               redirect_valid, redirect_pc, flush, eret, EXC_V); end
        // Inputs keep presenting an exception through the flush window.
        checks++; if (kill !== 2'b01) begin
            errors++; $display("FAIL s0exc_flush_kill: got %b want 01", kill); end
        tick();
        checks++; if (exc_valid !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL s0exc_t2_quiet: got v=%b rv=%b want 0/0", exc_valid, redirect_valid); end
        tick();
        checks++; if (exc_valid !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL s0exc_t3_quiet: got v=%b fl=%b want 0/0", exc_valid, flush); end
        // First IDLE cycle after the window takes the still-present exception.
        checks++; if (kill !== 2'b11) begin
            errors++; $display("FAIL s0exc_retake_kill: got %b want 11", kill); end
        settle();
    endtask

    task automatic test_slot1_exc();
        slot_valid = 2'b11; slot_exc = 2'b10; slot_code[1] = 5'd10; slot_in_ds = 2'b10;
        slot_pc[0] = 32'h8000_0100; slot_pc[1] = 32'h8000_0104;
        #1;
        checks++; if (kill !== 2'b10) begin
            errors++; $display("FAIL s1exc_kill: got %b want 10", kill); end
        tick();
        checks++; if (exc_valid !== 1'b1 || exc_pc !== 32'h8000_0104 || exc_in_ds !== 1'b1 || exc_code !== 5'd10) begin
            errors++; $display("FAIL s1exc_record: got v=%b pc=%h ds=%b code=%0d want 1/80000104/1/10",
                               exc_valid, exc_pc, exc_in_ds, exc_code); end
        settle();
    endtask

    task automatic test_interrupt();
        status_ie = 1'b1; status_im = 8'h10; ext_int = 6'b000100;
        tick();
        checks++; if (ip_hw[2] !== 1'b0) begin
            errors++; $display("FAIL irq_ip_early: got %b want 0", ip_hw[2]); end
        tick();
        checks++; if (ip_hw[2] !== 1'b1) begin
            errors++; $display("FAIL irq_ip_sync: got %b want 1", ip_hw[2]); end
        slot_valid = 2'b01; slot_exc = 2'b01; slot_code[0] = 5'd8; slot_pc[0] = 32'h8000_0200;
        slot_badvaddr[0] = 32'hDEAD_BEEF;
        #1;
        checks++; if (kill !== 2'b11) begin
            errors++; $display("FAIL irq_kill: got %b want 11", kill); end
        tick();
        checks++; if (exc_valid !== 1'b1 || exc_code !== 5'd0 || exc_pc !== 32'h8000_0200 || exc_badvaddr !== 32'd0) begin
            errors++; $display("FAIL irq_record: got v=%b code=%0d pc=%h bad=%h want 1/0/80000200/0",
                               exc_valid, exc_code, exc_pc, exc_badvaddr); end
        settle();
    endtask

    task automatic test_eret();
        slot_valid = 2'b11; slot_eret = 2'b10; epc = 32'h8000_2000;
        #1;
        checks++; if (kill !== 2'b10) begin
            errors++; $display("FAIL eret_kill: got %b want 10", kill); end
        tick();
        epc = 32'h1234_5678;
        checks++; if (eret !== 1'b1 || exc_valid !== 1'b0 || redirect_pc !== 32'h8000_2000 || flush !== 1'b1) begin
            errors++; $display("FAIL eret_record: got eret=%b v=%b pc=%h fl=%b want 1/0/80002000/1",
                               eret, exc_valid, redirect_pc, flush); end
        settle();
        // Exception and ERET on the same slot: the exception wins.
        slot_valid = 2'b01; slot_eret = 2'b01; slot_exc = 2'b01; slot_code[0] = 5'd5;
        tick();
        checks++; if (exc_valid !== 1'b1 || eret !== 1'b0) begin
            errors++; $display("FAIL exc_over_eret: got v=%b eret=%b want 1/0", exc_valid, eret); end
        settle();
    endtask

    task automatic test_refill();
        for (int e = 0; e < 2; e++) begin
            slot_valid = 2'b01; slot_exc = 2'b01; slot_code[0] = 5'd2; slot_refill = 2'b01;
            status_exl = e[0];
            tick();
            checks++; if (redirect_pc !== (e == 0 ? REF_V : EXC_V)) begin
                errors++; $display("FAIL refill_exl%0d: got %h want %h", e, redirect_pc, (e == 0 ? REF_V : EXC_V)); end
            settle();
        end
    endtask

    task automatic test_reset_in_flush();
        slot_valid = 2'b01; slot_exc = 2'b01; slot_code[0] = 5'd4;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({exc_valid, eret, redirect_valid, flush} !== 4'b0000 || redirect_pc !== 32'd0 || exc_code !== 5'd0) begin
            errors++; $display("FAIL rstflush_outputs: got %b pc=%h code=%0d want 0000/0/0",
                               {exc_valid, eret, redirect_valid, flush}, redirect_pc, exc_code); end
        checks++; if (kill !== 2'b11) begin
            errors++; $display("FAIL rstflush_kill: got %b want 11", kill); end
        tick();
        checks++; if (exc_valid !== 1'b1) begin
            errors++; $display("FAIL rstflush_retake: got %b want 1", exc_valid); end
        settle();
    endtask

    task automatic randomize_inputs();
        reset       = ($urandom_range(0, 59) == 0);
        slot_valid  = 2'($urandom);
        slot_in_ds  = 2'($urandom);
        slot_refill = 2'($urandom);
        for (int i = 0; i < 2; i++) begin
            slot_exc[i]      = ($urandom_range(0, 4) == 0);
            slot_eret[i]     = ($urandom_range(0, 7) == 0);
            slot_pc[i]       = $urandom;
            slot_badvaddr[i] = $urandom;
            slot_code[i]     = ($urandom_range(0, 2) == 0) ? 5'(2 + $urandom_range(0, 1)) : 5'($urandom);
        end
        status_ie       = $urandom_range(0, 1) == 1;
        status_exl      = ($urandom_range(0, 3) == 0);
        status_erl      = ($urandom_range(0, 7) == 0);
        status_im       = 8'($urandom);
        cause_ip_sw     = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
        epc             = $urandom;
        timer_interrupt = ($urandom_range(0, 11) == 0);
        ext_int         = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0;
    endtask

    task automatic test_random(input int n);
        dec_t d;
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_busy = 0; m_ext_d1 = '0; m_ext_d2 = '0; m_exp = '0;
        for (int c = 0; c < n; c++) begin
            randomize_inputs();
            #1;
            d = decide();
            checks++; if (kill !== d.kill) begin
                errors++; $display("FAIL rnd_kill c=%0d: got %b want %b", c, kill, d.kill); end
            checks++; if (ip_hw !== model_ip()) begin
                errors++; $display("FAIL rnd_ip_hw c=%0d: got %b want %b", c, ip_hw, model_ip()); end
            @(posedge clk);
            if (reset) begin
                m_busy = 0; m_ext_d1 = '0; m_ext_d2 = '0; m_exp = '0;
            end else begin
                m_ext_d2 = m_ext_d1;
                m_ext_d1 = ext_int;
                if (m_busy > 0) begin
                    m_busy--;
                    m_exp = '0;
                end else begin
                    m_exp = d;
                    if (d.ev) m_busy = FC;
                end
            end
            #1;
            checks++; if (exc_valid !== (m_exp.ev & ~m_exp.is_eret) || eret !== (m_exp.ev & m_exp.is_eret) ||
                          redirect_valid !== m_exp.ev || flush !== m_exp.ev) begin
                errors++; $display("FAIL rnd_flags c=%0d: got v=%b eret=%b rv=%b fl=%b want ev=%b is_eret=%b",
                                   c, exc_valid, eret, redirect_valid, flush, m_exp.ev, m_exp.is_eret); end
            if (m_exp.ev) begin
                checks++; if (redirect_pc !== m_exp.tgt) begin
                    errors++; $display("FAIL rnd_redirect_pc c=%0d: got %h want %h", c, redirect_pc, m_exp.tgt); end
            end
            if (m_exp.ev && !m_exp.is_eret) begin
                checks++; if (exc_code !== m_exp.code || exc_pc !== m_exp.pc || exc_in_ds !== m_exp.ds ||
                              exc_badvaddr !== m_exp.bad) begin
                    errors++; $display("FAIL rnd_record c=%0d: got %0d/%h/%b/%h want %0d/%h/%b/%h", c,
                                       exc_code, exc_pc, exc_in_ds, exc_badvaddr,
                                       m_exp.code, m_exp.pc, m_exp.ds, m_exp.bad); end
            end
        end
        settle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_slot0_exc();
        test_slot1_exc();
        test_interrupt();
        test_eret();
        test_refill();
        test_reset_in_flush();
        test_random(1500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_commit.md
# exc_commit

Commit-stage exception and interrupt arbiter for the dual-issue in-order core. It sits directly upstream of the CP0 register file. Each cycle it examines the two committing slots and the CP0 status and interrupt state, then picks at most one event: an interrupt, an exception or an ERET. It kills the affected slot writebacks in the same cycle, and one cycle later delivers a registered exception/ERET record to CP0 together with a front-end redirect and pipeline flush.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry
- REFILL_VECTOR, 32'hBFC0_0200, TLB-refill entry (TLBL/TLBS with refill flag while EXL=0)
- FLUSH_CYCLES, 2, cycles commit inputs are ignored after a redirect (1..7)

Ports (slot 0 is the older instruction; `[1:0]` marks per-slot signals):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- slot_valid[1:0]  in  2  slot holds a committing instruction
- slot_pc[1:0]  in  2x32  slot PC
- slot_in_ds[1:0]  in  2  slot is a branch delay slot
- slot_exc[1:0]  in  2  slot carries an exception flagged earlier in the pipe
- slot_code[1:0]  in  2x5  that slot's exception code
- slot_badvaddr[1:0]  in  2x32  that slot's faulting address
- slot_refill[1:0]  in  2  the slot's TLB miss is a refill (no matching entry)
- slot_eret[1:0]  in  2  slot is ERET
- status_ie, status_exl, status_erl  in  1 each  CP0 Status bits
- status_im  in  8  Status.IM
- cause_ip_sw  in  2  Cause.IP[1:0]
- epc  in  32  CP0 EPC
- timer_interrupt  in  1  registered timer request from CP0
- ext_int  in  6  asynchronous hardware interrupt lines
- kill  out  2  combinational per-slot writeback suppress
- exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr  out  1/5/32/1/32  registered exception record to CP0
- eret  out  1  registered ERET pulse to CP0
- redirect_valid, redirect_pc  out  1/32  registered front-end redirect
- flush  out  1  registered pipeline flush, asserted together with redirect_valid
- ip_hw  out  6  Cause.IP[7:2] value for CP0

## Operation
- Interrupt synchronizer: ext_int passes through a 2-flop synchronizer to give int_s.
- ip_hw = {int_s[5] | timer_interrupt, int_s[4:0]}.
- Interrupt request: int_req = status_ie & ~status_exl & ~status_erl & |({ip_hw, cause_ip_sw} & status_im).
- FSM states:
  - IDLE: evaluate the slots.
  - FLUSH: ignore all slot inputs, kill = slot_valid; a 3-bit counter loads FLUSH_CYCLES-1 and counts down; return to IDLE when the counter is 0.
- Evaluation in IDLE, at cycle T:
  - The oldest valid slot is slot 0 if slot_valid[0], else slot 1.
  - Event priority: interrupt (int_req and any valid slot) on the oldest valid slot, then slot 0 exception, then slot 0 ERET, then slot 1 exception, then slot 1 ERET.
  - Interrupt: code 0, badvaddr 0, pc/in_ds taken from that slot.
- Kill rules:
  - An event on slot 0 kills both slots.
  - An event on slot 1 kills slot 1 only; slot 0 retires.
  - No event: kill = 0.
- Redirect target:
  - Exception or interrupt: REFILL_VECTOR if code is TLBL(2) or TLBS(3), slot_refill is set and status_exl=0; otherwise EXC_VECTOR.
  - ERET: epc as sampled at T.
- Any event moves the FSM IDLE -> FLUSH.
- Same slot with both exc and eret: the exception wins and eret stays 0.

## Timing
- kill is combinational in cycle T.
- exc_*, eret, redirect_*, flush are registered: valid for exactly one cycle at T+1; exc_valid and eret are never both 1.
- The FLUSH state occupies cycles T+1 .. T+FLUSH_CYCLES. An event can next be taken at T+FLUSH_CYCLES+1.
- ext_int to ip_hw latency is 2 cycles. timer_interrupt is used unsynchronized, with 0 extra cycles.
- Reset, including mid-FLUSH: state IDLE, counter 0, synchronizer flops 0, all registered outputs 0. kill follows its combinational rule in IDLE, so it is 0 with no event. ip_hw = {timer_interrupt, 5'b0}.
- status_* and epc are sampled at T. CP0 updates at T+1 do not affect the T decision.

## Test plan
- Slot 0 exc, code 4 (AdEL), pc 0x8000_1000, badvaddr 0x0000_0003 -> kill=11 at T; at T+1 exc_valid=1, code 4, exc_badvaddr 0x3, redirect_pc 0xBFC0_0380, flush=1; slot inputs during T+1..T+2 produce no events.
- Slot 0 clean, slot 1 exc code 10 with in_ds=1 -> kill=10; exc_pc = slot 1 pc, exc_in_ds=1.
- ext_int[2]=1, status_im[4]=1, IE=1, EXL=0 -> ip_hw[2]=1 after 2 cycles. The next cycle with a valid slot wins over a simultaneous slot 0 syscall: exc_code=0.
- Slot 1 ERET with epc 0x8000_2000 and no exceptions -> kill=10, eret=1 at T+1, redirect_pc 0x8000_2000.
- Slot 0 TLBL (code 2) with refill=1: EXL=0 -> redirect_pc 0xBFC0_0200; EXL=1 -> redirect_pc 0xBFC0_0380.
- reset asserted at T+1 inside FLUSH -> all registered outputs 0 at T+2. A slot 0 exception at T+2 is taken: exc_valid=1 at T+3.
